// File: rtl/id_ex_stage_if.sv
// Bundle of every signal between the ID/EX stage and its neighbours: the decode-side
// handshake, the execute-side handshake, the flush request and the stage status.
interface id_ex_stage_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16
);
  // Valid/ready semantics on both sides: a transfer happens on a rising edge where valid
  // and ready are both 1; valid never waits for ready, and payload is only meaningful
  // while valid is 1 (the stage still drives zeros on its outputs when empty).
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic              halted;

  modport master (
    output clear, in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy, halted
  );

  modport slave (
    input  clear, in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy, halted
  );
endinterface

// File: rtl/id_ex_stage.sv
// Elastic ID/EX register: 2-entry skid buffer with synchronous flush and halt freeze.
// DATA_W/CTRL_W must match the parameters of the connected id_ex_stage_if instance.
module id_ex_stage #(
  parameter int DATA_W   = 96,
  parameter int CTRL_W   = 16,
  parameter int HALT_EN  = 1,
  parameter int HALT_BIT = 15
) (
  input logic           clk,
  input logic           reset,
  id_ex_stage_if.slave  bus
);

  // Occupancy doubles as the state of the buffer; it is exposed on bus.occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } cnt_t;

  cnt_t              cnt, cntNext;
  logic              hlt, hltNext;
  logic [DATA_W-1:0] mData, mDataNext, sData, sDataNext;
  logic [CTRL_W-1:0] mCtrl, mCtrlNext, sCtrl, sCtrlNext;
  logic              push, pop, haltIn;

  assign bus.in_ready  = (cnt != FULL) && !hlt && !bus.clear;
  assign bus.out_valid = (cnt != EMPTY);
  assign bus.out_data  = mData;
  assign bus.out_ctrl  = mCtrl;
  assign bus.occupancy = cnt;
  assign bus.halted    = hlt;

  assign push   = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;
  assign haltIn = (HALT_EN != 0) && bus.in_ctrl[HALT_BIT];

  always_comb begin
    cntNext   = cnt;
    hltNext   = hlt;
    mDataNext = mData;
    mCtrlNext = mCtrl;
    sDataNext = sData;
    sCtrlNext = sCtrl;
    if (bus.clear) begin
      cntNext   = EMPTY;
      hltNext   = 1'b0;
      mDataNext = '0;
      mCtrlNext = '0;
      sDataNext = '0;
      sCtrlNext = '0;
    end else begin
      case (cnt)
        EMPTY: begin
          if (push) begin
            mDataNext = bus.in_data;
            mCtrlNext = bus.in_ctrl;
            cntNext   = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            mDataNext = bus.in_data;
            mCtrlNext = bus.in_ctrl;
          end else if (push) begin
            sDataNext = bus.in_data;
            sCtrlNext = bus.in_ctrl;
            cntNext   = FULL;
          end else if (pop) begin
            // Empty head goes back to zero so execute sees a NOP bubble.
            mDataNext = '0;
            mCtrlNext = '0;
            cntNext   = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            mDataNext = sData;
            mCtrlNext = sCtrl;
            sDataNext = '0;
            sCtrlNext = '0;
            cntNext   = ONE;
          end
        end
        default: cntNext = EMPTY;
      endcase
      if (push && haltIn) hltNext = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= EMPTY;
      hlt   <= 1'b0;
      mData <= '0;
      mCtrl <= '0;
      sData <= '0;
      sCtrl <= '0;
    end else begin
      cnt   <= cntNext;
      hlt   <= hltNext;
      mData <= mDataNext;
      mCtrl <= mCtrlNext;
      sData <= sDataNext;
      sCtrl <= sCtrlNext;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed steps from the test plan followed by random traffic,
// all compared against a queue-based model of an in-order 2-deep buffer with halt/flush.
module tb_id_ex_stage;
  localparam int DATA_W = 96;
  localparam int CTRL_W = 16;
  localparam int E_W    = DATA_W + CTRL_W;

  logic clk;
  logic reset;

  id_ex_stage_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  id_ex_stage #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .HALT_EN(1), .HALT_BIT(15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [E_W-1:0] exp_q[$];
  logic           m_hlt;
  int             passed;
  int             total;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_ctrl  = c;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_hlt = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the rising edge.
  task automatic cycle();
    logic           exp_ready, do_push, do_pop;
    logic [E_W-1:0] head;
    @(negedge clk);
    exp_ready = (exp_q.size() < 2) && !m_hlt && !bus.clear;
    head      = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("out_valid", bus.out_valid, exp_q.size() != 0);
    check("out_data",  bus.out_data,  head[DATA_W-1:0]);
    check("out_ctrl",  bus.out_ctrl,  head[E_W-1:DATA_W]);
    check("occupancy", bus.occupancy, exp_q.size());
    check("halted",    bus.halted,    m_hlt);
    check("in_ready",  bus.in_ready,  exp_ready);
    do_push = bus.in_valid && exp_ready;
    do_pop  = (exp_q.size() != 0) && bus.out_ready;
    @(posedge clk);
    if (bus.clear) begin
      model_reset();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back({bus.in_ctrl, bus.in_data});
        if (bus.in_ctrl[15]) m_hlt = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    model_reset();
    reset         = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0);

    // Reset state.
    #12;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data",  bus.out_data,  '0);
    check("rst_out_ctrl",  bus.out_ctrl,  '0);
    check("rst_occupancy", bus.occupancy, 2'd0);
    check("rst_halted",    bus.halted,    1'b0);
    reset = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Back-to-back pushes with execute always ready.
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DATA_W'(i), 16'h0011);
      cycle();
    end
    drive(1'b0, '0, '0);
    repeat (2) cycle();

    // Fill under stall, then drain in order.
    bus.out_ready = 1'b0;
    drive(1'b1, DATA_W'(32'hA), 16'h0022);
    cycle();
    drive(1'b1, DATA_W'(32'hB), 16'h0033);
    cycle();
    drive(1'b1, DATA_W'(32'hC), 16'h0044);
    cycle();
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b1;
    repeat (3) cycle();

    // Flush while full, with an offered entry and a pop in the same cycle.
    bus.out_ready = 1'b0;
    drive(1'b1, DATA_W'(32'h51), 16'h0001);
    cycle();
    drive(1'b1, DATA_W'(32'h52), 16'h0002);
    cycle();
    bus.out_ready = 1'b1;
    drive(1'b1, DATA_W'(32'h53), 16'h0003);
    bus.clear = 1'b1;
    cycle();
    bus.clear = 1'b0;
    drive(1'b0, '0, '0);
    cycle();

    // Halt freeze: only the halt entry emerges, then clear releases it.
    drive(1'b1, DATA_W'(32'h77), 16'h8001);
    cycle();
    drive(1'b1, DATA_W'(32'h99), 16'h0005);
    repeat (3) cycle();
    bus.clear = 1'b1;
    cycle();
    bus.clear = 1'b0;
    drive(1'b0, '0, '0);
    cycle();

    // Asynchronous reset between edges while full.
    bus.out_ready = 1'b0;
    drive(1'b1, DATA_W'(32'hE1), 16'h0101);
    cycle();
    drive(1'b1, DATA_W'(32'hE2), 16'h0202);
    cycle();
    drive(1'b0, '0, '0);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_out_data",  bus.out_data,  '0);
    check("arst_out_ctrl",  bus.out_ctrl,  '0);
    check("arst_occupancy", bus.occupancy, 2'd0);
    @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    cycle();

    // Random traffic with a 30% execute stall rate, rare halts and flushes.
    for (int n = 0; n < 10000; n++) begin
      bus.out_ready = ($urandom_range(0, 99) >= 30);
      drive($urandom_range(0, 99) < 70, {$urandom(), $urandom(), $urandom()},
            {($urandom_range(0, 99) < 2), 15'($urandom())});
      bus.clear = m_hlt ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) == 0);
      cycle();
    end
    bus.clear = 1'b0;
    drive(1'b0, '0, '0);
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
